// File: rtl/complex_fifo.sv
// First-word-fall-through FIFO of complex samples (real/imag stored as one entry).
// Optional registered occupancy port enabled by defining COMPLEX_FIFO_COUNT_EN.
module complex_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_r,
   input  logic signed [DATA_W-1:0] in_i,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_r,
   output logic signed [DATA_W-1:0] out_i,
   output logic                     full,
   output logic                     empty
`ifdef COMPLEX_FIFO_COUNT_EN
   ,
   output logic [$clog2(DEPTH):0]   count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_OCC = (AW+1)'(DEPTH);

   logic signed [DATA_W-1:0] mem_r [DEPTH];
   logic signed [DATA_W-1:0] mem_i [DEPTH];
   logic [AW-1:0]            wptr;
   logic [AW-1:0]            rptr;
   logic [AW:0]              occ;
   logic                     push;
   logic                     pop;

   // Full/empty come from the occupancy counter so wrapped pointers never alias.
   assign full      = (occ == DEPTH_OCC);
   assign empty     = (occ == '0);
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign out_r = empty ? '0 : mem_r[rptr];
   assign out_i = empty ? '0 : mem_i[rptr];

`ifdef COMPLEX_FIFO_COUNT_EN
   assign count = occ;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
         occ  <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // Storage has no reset; a push coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (rst && push) begin
         mem_r[wptr] <= in_r;
         mem_i[wptr] <= in_i;
      end
   end

endmodule

// File: tb/tb_complex_fifo.sv
// Randomized and directed bench for complex_fifo (DATA_W=16, DEPTH=4) against a queue model.
module tb_complex_fifo;

   localparam int DW = 16;
   localparam int DP = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_r;
   logic [DW-1:0] in_i;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_r;
   logic [DW-1:0] out_i;
   logic          full;
   logic          empty;
`ifdef COMPLEX_FIFO_COUNT_EN
   logic [2:0]    count;
`endif

   int total = 0;
   int bad   = 0;
   logic [31:0] q[$];

   always #5 clk = ~clk;

   complex_fifo #(.DATA_W(DW), .DEPTH(DP)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
      .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
      .full(full), .empty(empty)
`ifdef COMPLEX_FIFO_COUNT_EN
      , .count(count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int n = q.size();
      chk({tag, "_empty"}, 32'(empty), 32'(n == 0));
      chk({tag, "_full"}, 32'(full), 32'(n == DP));
      chk({tag, "_in_ready"}, 32'(in_ready), 32'(n != DP));
      chk({tag, "_out_valid"}, 32'(out_valid), 32'(n != 0));
      chk({tag, "_out_r"}, 32'(out_r), (n != 0) ? 32'(q[0][31:16]) : 32'd0);
      chk({tag, "_out_i"}, 32'(out_i), (n != 0) ? 32'(q[0][15:0]) : 32'd0);
`ifdef COMPLEX_FIFO_COUNT_EN
      chk({tag, "_count"}, 32'(count), 32'(n));
`endif
   endtask

   // One clock: apply inputs, advance the model by the FIFO rules, check just after the edge.
   task automatic cycle(input string tag, input logic rn, input logic iv,
                        input logic [DW-1:0] ir, input logic [DW-1:0] ii, input logic ordy);
      rst = rn; in_valid = iv; in_r = ir; in_i = ii; out_ready = ordy;
      @(posedge clk);
      if (!rn) q.delete();
      else begin
         bit can_pop  = (q.size() > 0) && ordy;
         bit can_push = iv && (q.size() < DP);
         if (can_pop) void'(q.pop_front());
         if (can_push) q.push_back({ir, ii});
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_r = '0; in_i = '0; out_ready = 1'b0;
      cycle("rst0", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      cycle("rst1", 1'b0, 1'b1, 16'h55, 16'h66, 1'b1);

      // single push of (1,-1)
      cycle("r033", 1'b1, 1'b1, 16'h0001, 16'hFFFF, 1'b0);
      chk("r033_r", 32'(out_r), 32'h0001);
      chk("r033_i", 32'(out_i), 32'hFFFF);
      cycle("r033_pop", 1'b1, 1'b0, 16'h0, 16'h0, 1'b1);

      // fill, drop fifth, drain in order
      for (int k = 1; k <= 5; k++) cycle("r034_fill", 1'b1, 1'b1, 16'(k), 16'h0, 1'b0);
      chk("r034_full", 32'(full), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         chk("r034_order", 32'(out_r), 32'(k));
         cycle("r034_drain", 1'b1, 1'b0, 16'h0, 16'h0, 1'b1);
      end
      chk("r034_empty", 32'(empty), 32'd1);

      // steady-state push+pop across pointer wrap
      cycle("r035_a", 1'b1, 1'b1, 16'd100, 16'h8000, 1'b0);
      cycle("r035_b", 1'b1, 1'b1, 16'd101, 16'h7FFF, 1'b0);
      for (int k = 0; k < 10; k++)
         cycle("r035_run", 1'b1, 1'b1, 16'(102 + k), 16'(k), 1'b1);

      // full: push and pop together -> only pop
      cycle("r036_f1", 1'b1, 1'b1, 16'd200, 16'd1, 1'b0);
      cycle("r036_f2", 1'b1, 1'b1, 16'd201, 16'd2, 1'b0);
      chk("r036_isfull", 32'(full), 32'd1);
      cycle("r036_pp", 1'b1, 1'b1, 16'd999, 16'd9, 1'b1);
      chk("r036_notfull", 32'(full), 32'd0);

      // reset while pushing with 3 entries
      cycle("r037_rst", 1'b0, 1'b1, 16'd5, 16'd5, 1'b0);
      chk("r037_empty", 32'(empty), 32'd1);
      cycle("r037_push", 1'b1, 1'b1, 16'd7, 16'd7, 1'b0);
      chk("r037_head", 32'(out_r), 32'd7);
      cycle("r037_pop", 1'b1, 1'b0, 16'd0, 16'd0, 1'b1);

      // out_ready on empty FIFO
      for (int k = 0; k < 5; k++) cycle("r038", 1'b1, 1'b0, 16'hABCD, 16'h1234, 1'b1);

      // randomized traffic with occasional reset
      for (int k = 0; k < 600; k++)
         cycle("rand", ($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)),
               16'($urandom), 16'($urandom), ($urandom_range(0, 2) != 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
